// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Purpose : Shared constants and types for the RAM-backed byte FIFO controller,
//           its RAM wrapper and its testbench.
// Contents: DW/AW/DEPTH sizing, derived compare constants, FSM state enum.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DW    = 8;          // data width, must match the RAM width
    localparam int AW    = 4;          // RAM address width
    localparam int DEPTH = 1 << AW;    // 16 entries

    // Occupancy value meaning "full", sized to the AW+1 bit count register.
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    // Last RAM address touched by the clear sweep.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// ram_fifo_ctrl_if
// Purpose : User-side bundle of the FIFO controller (push/pop handshakes,
//           clear request, pop data and status flags).
// Signals : enq, din, deq, clr     - requests from the producer/consumer
//           dout, dout_vld         - pop data and its valid strobe
//           full, empty, count     - occupancy status
//           busy                   - clear sweep in progress
// Modports: master - the FIFO user; slave - the controller.
// -----------------------------------------------------------------------------
interface ram_fifo_ctrl_if
    import fifo_pkg::*;
();

    logic          enq;
    logic [DW-1:0] din;
    logic          deq;
    logic          clr;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          busy;

    modport master (
        output enq, din, deq, clr,
        input  dout, dout_vld, full, empty, count, busy
    );

    modport slave (
        input  enq, din, deq, clr,
        output dout, dout_vld, full, empty, count, busy
    );

endinterface

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Purpose : AW-bit wrap-around pointer used for the write pointer, the read
//           pointer and the clear-sweep address.
// Ports   : clk    - system clock
//           rst    - synchronous active-high reset (pointer -> 0)
//           clr_i  - synchronous clear to 0 (wins over inc_i)
//           inc_i  - advance by one, wrapping DEPTH-1 -> 0
//           ptr_o  - current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr
    import fifo_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;

    // NOTE: sequential state is assigned with <= only, so every register
    // samples the pre-edge values of its neighbours regardless of block order.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            ptr_q <= '0;
        end else if (inc_i) begin
            ptr_q <= ptr_q + AW'(1);   // natural wrap at 2**AW
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// ram_fifo_ctrl
// Purpose : Turns a 16x8 single-port synchronous RAM (1-cycle read latency)
//           into a 16-entry byte queue with push/pop handshakes, occupancy
//           flags and a 16-cycle sweep-clear. Owns every RAM control pin.
// Ports   : clk       - system clock (also the RAM clock)
//           rst       - synchronous active-high reset
//           fifo      - user-side interface (slave modport)
//           ram_en    - RAM enable
//           ram_we    - RAM write enable
//           ram_addr  - RAM address
//           ram_din   - RAM write data
//           ram_dout  - RAM read data (valid the cycle after a read)
// Notes   : One RAM access per cycle, priority clr > deq > enq. A push that
//           collides with a pop is dropped; the producer must retry.
// -----------------------------------------------------------------------------
module ram_fifo_ctrl
    import fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    ram_fifo_ctrl_if.slave        fifo,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [DW-1:0]         ram_din,
    input  logic [DW-1:0]         ram_dout
);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          dout_vld_q;

    logic [AW-1:0] wp, rp, sweep_addr;
    logic          empty, full;
    logic          in_idle, in_sweep;
    logic          clr_start, deq_fire, enq_fire, sweep_done;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

    // Requests are qualified with !rst so reset also silences the RAM pins
    // in its own cycle.
    assign in_idle    = (state_q == IDLE)  && !rst;
    assign in_sweep   = (state_q == CLEAR) && !rst;

    assign clr_start  = in_idle && fifo.clr;
    assign deq_fire   = in_idle && fifo.deq && !empty && !fifo.clr;
    assign enq_fire   = in_idle && fifo.enq && !full  && !deq_fire && !fifo.clr;
    assign sweep_done = in_sweep && (sweep_addr == LAST_ADDR);

    // Pointers only return to 0 at the end of a sweep; during the sweep no
    // push/pop can fire, so their stale values are never observed.
    fifo_ptr u_wp (
        .clk   (clk),
        .rst   (rst),
        .clr_i (sweep_done),
        .inc_i (enq_fire),
        .ptr_o (wp)
    );

    fifo_ptr u_rp (
        .clk   (clk),
        .rst   (rst),
        .clr_i (sweep_done),
        .inc_i (deq_fire),
        .ptr_o (rp)
    );

    fifo_ptr u_sweep (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_start),
        .inc_i (in_sweep),
        .ptr_o (sweep_addr)
    );

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    count_d = '0;
                end else if (deq_fire) begin
                    count_d = count_q - (AW+1)'(1);
                end else if (enq_fire) begin
                    count_d = count_q + (AW+1)'(1);
                end
            end
            CLEAR: begin
                if (sweep_done) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // RAM control is combinational so the access issues in the request cycle.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (in_sweep) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = sweep_addr;
        end else if (deq_fire) begin
            ram_en   = 1'b1;
            ram_addr = rp;
        end else if (enq_fire) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wp;
            ram_din  = fifo.din;
        end
    end

    // NOTE: only control state is reset here; the RAM array itself is never
    // reset and is zeroed solely by the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dout_vld_q <= deq_fire;   // matches the RAM's 1-cycle read latency
        end
    end

    assign fifo.dout     = ram_dout;
    assign fifo.dout_vld = dout_vld_q;
    assign fifo.full     = full;
    assign fifo.empty    = empty;
    assign fifo.count    = count_q;
    assign fifo.busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_fifo_ctrl
// Purpose : Self-checking bench for ram_fifo_ctrl with a behavioural RAM,
//           a queue-based reference model and a pop-data scoreboard.
// -----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;
    import fifo_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic [DW-1:0] mem [DEPTH];

    ram_fifo_ctrl_if fifo ();

    ram_fifo_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .fifo     (fifo),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    // Reference model: queue contents, totals of accepted pushes/pops since
    // the last clear/reset, and remaining sweep cycles.
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];
    int            push_total = 0;
    int            pop_total  = 0;
    int            sweep_left = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: check status left by the previous edge, drive
    // inputs, predict and check the RAM access this cycle, advance the model.
    task automatic step(input bit e, input logic [DW-1:0] d, input bit q,
                        input bit c, input bit r = 1'b0);
        bit            exp_en, exp_we;
        int            exp_addr;
        logic [DW-1:0] exp_din;
        @(negedge clk);
        check("count", 32'(fifo.count), 32'(model_q.size()));
        check("empty", 32'(fifo.empty), 32'(model_q.size() == 0));
        check("full",  32'(fifo.full),  32'(model_q.size() == DEPTH));
        check("busy",  32'(fifo.busy),  32'(sweep_left > 0));
        rst       = r;
        fifo.enq  = e;
        fifo.din  = d;
        fifo.deq  = q;
        fifo.clr  = c;
        #1;
        exp_en = 1'b0; exp_we = 1'b0; exp_addr = 0; exp_din = '0;
        if (r) begin
            model_q.delete();
            push_total = 0; pop_total = 0; sweep_left = 0;
        end else if (sweep_left > 0) begin
            exp_en = 1'b1; exp_we = 1'b1;
            exp_addr = DEPTH - sweep_left;
            sweep_left--;
        end else if (c) begin
            model_q.delete();
            push_total = 0; pop_total = 0; sweep_left = DEPTH;
        end else if (q && model_q.size() > 0) begin
            exp_en = 1'b1;
            exp_addr = pop_total % DEPTH;
            exp_q.push_back(model_q.pop_front());
            pop_total++;
        end else if (e && model_q.size() < DEPTH) begin
            exp_en = 1'b1; exp_we = 1'b1;
            exp_addr = push_total % DEPTH;
            exp_din = d;
            model_q.push_back(d);
            push_total++;
        end
        check("ram_en", 32'(ram_en), 32'(exp_en));
        check("ram_we", 32'(ram_we), 32'(exp_we));
        if (exp_en) check("ram_addr", 32'(ram_addr), 32'(exp_addr));
        if (exp_we) check("ram_din",  32'(ram_din),  32'(exp_din));
    endtask

    // Monitor: one cycle after each accepted pop the DUT must present valid
    // data; otherwise dout_vld must be low.
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                check("dout_vld", 32'(fifo.dout_vld), 32'd1);
                check("dout", 32'(fifo.dout), 32'(exp_q.pop_front()));
            end else begin
                check("dout_vld_idle", 32'(fifo.dout_vld), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        fifo.enq = 1'b0; fifo.din = '0; fifo.deq = 1'b0; fifo.clr = 1'b0;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // Three pushes, three back-to-back pops.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        repeat (3) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Fill across the wrap, push while full, drain, pop while empty.
        repeat (16) step(1, DW'($urandom), 0, 0);
        step(1, 8'hEE, 0, 0);
        repeat (16) step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Simultaneous enq+deq: pops win until empty, then the push lands.
        step(1, 8'h5A, 0, 0);
        step(1, 8'h6B, 0, 0);
        repeat (3) step(1, 8'hA5, 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);

        // Clear sweep with a pop in the cycle before clr and requests ignored.
        repeat (5) step(1, DW'($urandom), 0, 0);
        step(0, '0, 1, 0);
        step(1, 8'h77, 0, 1);
        repeat (16) step(1, DW'($urandom), 1'($urandom), 1'($urandom));
        step(0, '0, 0, 0);
        step(1, 8'hC3, 0, 0);
        step(1, 8'h3C, 0, 0);
        repeat (2) step(0, '0, 1, 0);

        // Reset at sweep cycle 7 aborts the sweep.
        repeat (3) step(1, DW'($urandom), 0, 0);
        step(0, '0, 0, 1);
        repeat (7) step(1, DW'($urandom), 0, 0);
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0);
        step(1, 8'h9D, 0, 0);
        step(0, '0, 1, 0);

        // Randomised traffic with occasional clears and resets.
        repeat (400) begin
            step(1'($urandom_range(0, 2) != 0), DW'($urandom),
                 1'($urandom_range(0, 2) == 0),
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 99) == 0);
        end

        repeat (3) step(0, '0, 0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
